// File: rtl/cbfp1_denorm_pkg.sv
// Shared widths, types and saturation helper for the stage-1 CBFP denormaliser.
// Pure definitions: no latency and no flow control.
package cbfp_pkg;
    localparam int IN_W        = 25;
    localparam int OUT_W       = 12;
    localparam int NCHAN       = 16;
    localparam int BLOCK_SIZE  = 8;
    localparam int NBLOCKS     = NCHAN / BLOCK_SIZE;
    localparam int TRUNC_VALUE = 13;
    localparam int FRAME_BEATS = 32;
    localparam int IDX_W       = $clog2(IN_W);
    localparam int SH_W        = 7;
    localparam int WIDE_W      = OUT_W + TRUNC_VALUE + 16;
    localparam int CNT_W       = $clog2(FRAME_BEATS);

    typedef logic signed [OUT_W-1:0] mant_t;
    typedef logic signed [IN_W-1:0]  full_t;
    typedef logic signed [IDX_W-1:0] idx_t;
    typedef logic signed [SH_W-1:0]  shift_t;

    localparam full_t FULL_MAX = {1'b0, {(IN_W-1){1'b1}}};
    localparam full_t FULL_MIN = {1'b1, {(IN_W-1){1'b0}}};

    localparam logic signed [WIDE_W-1:0] WIDE_MAX = {{(WIDE_W-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] WIDE_MIN = {{(WIDE_W-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};

    function automatic full_t sat_full(input logic signed [WIDE_W-1:0] v);
        if (v > WIDE_MAX)
            return FULL_MAX;
        else if (v < WIDE_MIN)
            return FULL_MIN;
        else
            return v[IN_W-1:0];
    endfunction
endpackage

// File: rtl/cbfp1_denorm_lane.sv
// One lane: shift a <6.6> mantissa back to <12.13> with saturation (combinational, no backpressure).
// CBFP1_DENORM_ROUND_EN selects round-half-up on right shifts; default truncates toward -inf.
module cbfp1_denorm_lane
    import cbfp_pkg::*;
(
    input  mant_t  mant,
    input  shift_t sh,
    output full_t  res
);
    logic signed [WIDE_W-1:0] ext;
    logic signed [WIDE_W-1:0] shl;
    logic signed [WIDE_W-1:0] shr;
    logic        [SH_W-1:0]   ramt;
`ifdef CBFP1_DENORM_ROUND_EN
    logic signed [WIDE_W-1:0] half;
`endif

    always_comb begin
        ext  = {{(WIDE_W-OUT_W){mant[OUT_W-1]}}, mant};
        ramt = SH_W'(-sh);
        shl  = ext <<< $unsigned(sh);
`ifdef CBFP1_DENORM_ROUND_EN
        half = WIDE_W'(1) << (ramt - 7'd1);
        shr  = (ext + half) >>> ramt;
`else
        shr  = ext >>> ramt;
`endif
        // The wide intermediate never wraps, so sat_full sees the true value.
        if (!sh[SH_W-1])
            res = sat_full(shl);
        else if (ramt >= 7'd24)
            res = {IN_W{mant[OUT_W-1]}};
        else
            res = sat_full(shr);
    end
endmodule

// File: rtl/cbfp1_denorm.sv
// Stage-1 CBFP denormaliser: 16 lanes/clock, 2-cycle latency, streaming with no backpressure.
// Adds sof/eof framing and a sticky index-mismatch flag; rounding via CBFP1_DENORM_ROUND_EN.
module cbfp1_denorm
    import cbfp_pkg::*;
(
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               valid_in,
    input  logic signed [NCHAN-1:0][OUT_W-1:0] data_re_in,
    input  logic signed [NCHAN-1:0][OUT_W-1:0] data_im_in,
    input  logic signed [NCHAN-1:0][IDX_W-1:0] idx1_in,
    input  logic                               err_clr,
    output logic signed [NCHAN-1:0][IN_W-1:0]  data_re_out,
    output logic signed [NCHAN-1:0][IN_W-1:0]  data_im_out,
    output logic                               valid_out,
    output logic                               sof_out,
    output logic                               eof_out,
    output logic                               idx_err
);
    mant_t  [NCHAN-1:0]   re_q, im_q;
    shift_t [NBLOCKS-1:0] sh_q, sh_d;
    full_t  [NCHAN-1:0]   re_s, im_s;
    logic                 vld_q, sof_q, eof_q;
    logic   [CNT_W-1:0]   cnt;
    logic                 mism;
    idx_t                 blk;

    always_comb begin
        mism = 1'b0;
        sh_d = '0;
        blk  = '0;
        for (int b = 0; b < NBLOCKS; b++) begin
            blk     = idx1_in[b*BLOCK_SIZE];
            sh_d[b] = shift_t'(TRUNC_VALUE) - {{(SH_W-IDX_W){blk[IDX_W-1]}}, blk};
            for (int l = 1; l < BLOCK_SIZE; l++)
                if (idx1_in[b*BLOCK_SIZE+l] != idx1_in[b*BLOCK_SIZE])
                    mism = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            cnt     <= '0;
            idx_err <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            sh_q    <= '0;
        end else begin
            vld_q   <= valid_in;
            // Set has priority over clear.
            idx_err <= (valid_in & mism) | (idx_err & ~err_clr);
            if (valid_in) begin
                re_q  <= data_re_in;
                im_q  <= data_im_in;
                sh_q  <= sh_d;
                sof_q <= (cnt == '0);
                eof_q <= (cnt == CNT_W'(FRAME_BEATS-1));
                cnt   <= (cnt == CNT_W'(FRAME_BEATS-1)) ? '0 : CNT_W'(cnt + 1'b1);
            end
        end
    end

    for (genvar i = 0; i < NCHAN; i++) begin : g_lane
        cbfp1_denorm_lane u_re (.mant(re_q[i]), .sh(sh_q[i/BLOCK_SIZE]), .res(re_s[i]));
        cbfp1_denorm_lane u_im (.mant(im_q[i]), .sh(sh_q[i/BLOCK_SIZE]), .res(im_s[i]));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out   <= 1'b0;
            sof_out     <= 1'b0;
            eof_out     <= 1'b0;
            data_re_out <= '0;
            data_im_out <= '0;
        end else begin
            valid_out <= vld_q;
            sof_out   <= vld_q & sof_q;
            eof_out   <= vld_q & eof_q;
            if (vld_q) begin
                data_re_out <= re_s;
                data_im_out <= im_s;
            end
        end
    end
endmodule

// File: tb/tb_cbfp1_denorm.sv
// Directed bench for cbfp1_denorm: restore values, saturation, index check, framing and reset flush.
module tb_cbfp1_denorm;
    import cbfp_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    logic valid_in;
    logic err_clr;
    logic signed [NCHAN-1:0][OUT_W-1:0] data_re_in, data_im_in;
    logic signed [NCHAN-1:0][IDX_W-1:0] idx1_in;
    logic signed [NCHAN-1:0][IN_W-1:0]  data_re_out, data_im_out;
    logic valid_out, sof_out, eof_out, idx_err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cbfp1_denorm dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in),
        .data_re_in(data_re_in), .data_im_in(data_im_in), .idx1_in(idx1_in),
        .err_clr(err_clr),
        .data_re_out(data_re_out), .data_im_out(data_im_out),
        .valid_out(valid_out), .sof_out(sof_out), .eof_out(eof_out), .idx_err(idx_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_all(input int re, input int im, input int idx);
        for (int l = 0; l < NCHAN; l++) begin
            data_re_in[l] = OUT_W'(re);
            data_im_in[l] = OUT_W'(im);
            idx1_in[l]    = IDX_W'(idx);
        end
    endtask

    task automatic chk_lanes(input string tag, input longint er, input longint ei);
        for (int l = 0; l < NCHAN; l++) begin
            chk($sformatf("%s_re%0d", tag, l), longint'($signed(data_re_out[l])), er);
            chk($sformatf("%s_im%0d", tag, l), longint'($signed(data_im_out[l])), ei);
        end
    endtask

    // One valid beat followed by one idle cycle; outputs are then at N+2.
    task automatic beat();
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
    endtask

    initial begin
        rstn = 1'b0; valid_in = 1'b0; err_clr = 1'b0;
        set_all(0, 0, 13);
        tick(); tick();
        chk("rst_valid", valid_out, 0);
        chk("rst_sof", sof_out, 0);
        chk("rst_eof", eof_out, 0);
        chk("rst_idx_err", idx_err, 0);
        chk("rst_data", longint'($signed(data_re_out[0])), 0);
        rstn = 1'b1;
        tick();

        // s = 0, exact latency of two cycles
        set_all(2047, -2048, 13);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        chk("lat_n1_valid", valid_out, 0);
        tick();
        chk("lat_n2_valid", valid_out, 1);
        chk_lanes("s0", 2047, -2048);
        tick();
        chk("lat_n3_valid", valid_out, 0);

        set_all(-1, 1, 0);
        beat();
        chk_lanes("s13", -8192, 8192);

        set_all(102, -3, 15);
        beat();
`ifdef CBFP1_DENORM_ROUND_EN
        chk_lanes("sm2", 26, -1);
`else
        chk_lanes("sm2", 25, -1);
`endif

        set_all(2047, -2048, -1);
        beat();
        chk_lanes("sat", 16777215, -16777216);

        // Mismatch on an idle cycle must not set the flag
        set_all(1, -1, 7);
        idx1_in[3] = IDX_W'(5);
        tick();
        chk("err_idle", idx_err, 0);

        err_clr  = 1'b1;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        err_clr  = 1'b0;
        chk("err_set_wins", idx_err, 1);
        tick();
        chk_lanes("mism", 64, -64);
        chk("err_sticky", idx_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", idx_err, 0);

        // Fresh frame from reset, 32 beats with 1-3 idle cycles between
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        for (int k = 0; k < FRAME_BEATS; k++) begin
            set_all(k, -k, 13);
            beat();
            chk($sformatf("frm%0d_valid", k), valid_out, 1);
            chk($sformatf("frm%0d_sof", k), sof_out, (k == 0) ? 1 : 0);
            chk($sformatf("frm%0d_eof", k), eof_out, (k == FRAME_BEATS-1) ? 1 : 0);
            chk($sformatf("frm%0d_re", k), longint'($signed(data_re_out[5])), k);
            chk($sformatf("frm%0d_im", k), longint'($signed(data_im_out[12])), -k);
            for (int g = 0; g < $urandom_range(0, 2); g++)
                tick();
        end

        // Reset with beat 10 in flight
        for (int k = 0; k < 9; k++) begin
            set_all(k, k, 13);
            beat();
        end
        chk("pre_rst_sof", sof_out, 0);
        set_all(9, 9, 13);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst_flush_valid", valid_out, 0);
        tick();
        rstn = 1'b1;
        tick();
        chk("rst_no_stale", valid_out, 0);
        tick();
        chk("rst_no_stale2", valid_out, 0);
        set_all(3, 3, 13);
        beat();
        chk("post_rst_valid", valid_out, 1);
        chk("post_rst_sof", sof_out, 1);
        chk("post_rst_eof", eof_out, 0);
        chk("post_rst_re", longint'($signed(data_re_out[0])), 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
